// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: drives the PC register and the instruction-memory handshake.
// Outputs the registered IF/ID instruction and flushes on trap or redirect.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        load_use_hazard,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        trap,
    output logic        flush,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc
);

    typedef enum logic [1:0] {StIdle, StReq, StHold, StDiscard} state_e;

    state_e      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        instr_valid_q;
    logic [31:0] instr_out_q, instr_pc_q;

    logic        accept;
    logic [31:0] accept_instr, accept_pc;
    logic        ctl_event;
    logic [31:0] event_target;
    logic [31:0] pc_inc;

    assign imem_addr   = pc_cur;
    assign instr_valid = instr_valid_q;
    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;

    always_comb begin
        ctl_event    = trap | redirect_valid;
        event_target = trap ? TRAP_VECTOR : {redirect_target[31:2], 2'b00};
        pc_inc       = pc_cur + 32'd4;

        state_d      = state_q;
        pending_d    = pending_q;
        buf_instr_d  = buf_instr_q;
        buf_pc_d     = buf_pc_q;
        accept       = 1'b0;
        accept_instr = buf_instr_q;
        accept_pc    = buf_pc_q;
        pc_next      = pc_cur;
        pc_stall     = 1'b1;
        flush        = 1'b0;
        imem_req     = 1'b0;

        case (state_q)
            StIdle: begin
                pc_stall = 1'b0;
                pc_next  = ctl_event ? event_target : RESET_PC;
                flush    = ctl_event;
                state_d  = StReq;
            end
            StReq: begin
                imem_req = 1'b1;
                if (ctl_event) begin
                    flush = 1'b1;
                    if (imem_ack) begin
                        pc_stall = 1'b0;
                        pc_next  = event_target;
                    end else begin
                        // Request cannot be withdrawn; remember where to go once it returns.
                        pending_d = event_target;
                        state_d   = StDiscard;
                    end
                end else if (imem_ack) begin
                    if (!load_use_hazard) begin
                        accept       = 1'b1;
                        accept_instr = imem_rdata;
                        accept_pc    = pc_cur;
                        pc_stall     = 1'b0;
                        pc_next      = pc_inc;
                    end else begin
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = pc_cur;
                        state_d     = StHold;
                    end
                end
            end
            StHold: begin
                if (ctl_event) begin
                    flush    = 1'b1;
                    pc_stall = 1'b0;
                    pc_next  = event_target;
                    state_d  = StReq;
                end else if (!load_use_hazard) begin
                    accept   = 1'b1;
                    pc_stall = 1'b0;
                    pc_next  = pc_inc;
                    state_d  = StReq;
                end
            end
            StDiscard: begin
                imem_req = 1'b1;
                if (ctl_event) begin
                    flush = 1'b1;
                    if (imem_ack) begin
                        pc_stall = 1'b0;
                        pc_next  = event_target;
                        state_d  = StReq;
                    end else begin
                        pending_d = event_target;
                    end
                end else if (imem_ack) begin
                    pc_stall = 1'b0;
                    pc_next  = pending_q;
                    state_d  = StReq;
                end
            end
            default: state_d = StIdle;
        endcase

        // Reset overrides everything so the PC and memory see a quiet interface.
        if (!reset) begin
            imem_req = 1'b0;
            flush    = 1'b0;
            pc_stall = 1'b1;
            pc_next  = RESET_PC;
            accept   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            pending_q     <= '0;
            buf_instr_q   <= '0;
            buf_pc_q      <= '0;
            instr_valid_q <= 1'b0;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
            instr_valid_q <= accept;
            if (accept) begin
                instr_out_q <= accept_instr;
                instr_pc_q  <= accept_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run against a
// transaction-level model of the fetch rules.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        load_use_hazard;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap;
    logic        flush;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .TRAP_VECTOR(32'h0000_0100)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_cur         (pc_cur),
        .pc_next        (pc_next),
        .pc_stall       (pc_stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .load_use_hazard(load_use_hazard),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .trap           (trap),
        .flush          (flush),
        .instr_valid    (instr_valid),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc)
    );

    // PC register model; a non-zero reset value shows the sequencer really loads RESET_PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_cur <= 32'h0000_0FF0;
        else if (!pc_stall) pc_cur <= pc_next;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack = 1'b0; imem_rdata = 32'h0; load_use_hazard = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0; trap = 1'b0;
    endtask

    // Leaves the bench at posedge+1 of the IDLE cycle.
    task automatic do_reset();
        step();
        reset = 1'b0;
        clear_inputs();
        repeat (2) step();
        reset = 1'b1;
    endtask

    // Reset, pass IDLE, then accept n sequential fetches.
    task automatic boot_and_fetch(input int n);
        do_reset();
        step();
        for (int i = 0; i < n; i++) begin
            imem_ack = 1'b1; imem_rdata = $urandom;
            step();
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) step();
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++;
            $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (flush !== 1'b0) begin errors++;
            $display("FAIL rst_flush got %b exp 0", flush); end
        checks++; if (pc_stall !== 1'b1) begin errors++;
            $display("FAIL rst_stall got %b exp 1", pc_stall); end
        checks++; if (pc_next !== 32'h0) begin errors++;
            $display("FAIL rst_pc_next got %h exp 0", pc_next); end
        checks++; if (instr_valid !== 1'b0) begin errors++;
            $display("FAIL rst_valid got %b exp 0", instr_valid); end
        trap = 1'b1; redirect_valid = 1'b1;
        #1;
        checks++; if (flush !== 1'b0) begin errors++;
            $display("FAIL rst_flush_ev got %b exp 0", flush); end
        clear_inputs();
        step();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (pc_stall !== 1'b0 || pc_next !== 32'h0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_out got stall %b next %h req %b exp 0 0 0",
                     pc_stall, pc_next, imem_req); end
        step();
        @(negedge clk);
        checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++;
            $display("FAIL first_req got addr %h req %b exp 0 1", imem_addr, imem_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] w [4];
        for (int k = 0; k < 4; k++) w[k] = 32'hA000_0000 + 32'(k);
        do_reset();
        step();
        for (int k = 0; k < 4; k++) begin
            imem_ack = 1'b1; imem_rdata = w[k];
            @(negedge clk);
            checks++; if (imem_addr !== 32'(4 * k) || imem_req !== 1'b1) begin errors++;
                $display("FAIL seq_addr got %h req %b exp %h 1", imem_addr, imem_req, 4 * k); end
            checks++; if (pc_stall !== 1'b0 || pc_next !== 32'(4 * k + 4)) begin errors++;
                $display("FAIL seq_next got %b %h exp 0 %h", pc_stall, pc_next, 4 * k + 4); end
            if (k == 0) begin
                checks++; if (instr_valid !== 1'b0) begin errors++;
                    $display("FAIL seq_valid0 got %b exp 0", instr_valid); end
            end else begin
                checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (k - 1)) ||
                              instr_out !== w[k-1]) begin errors++;
                    $display("FAIL seq_instr got %b %h %h exp 1 %h %h", instr_valid,
                             instr_pc, instr_out, 4 * (k - 1), w[k-1]); end
            end
            step();
        end
        imem_ack = 1'b0;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hC || instr_out !== w[3] ||
                      pc_stall !== 1'b1) begin errors++;
            $display("FAIL seq_last got %b %h %h stall %b exp 1 c %h 1", instr_valid,
                     instr_pc, instr_out, w[3], pc_stall); end
        step();
    endtask

    task automatic test_delayed_ack();
        boot_and_fetch(2);
        for (int c = 0; c < 4; c++) begin
            imem_ack = (c == 3); imem_rdata = 32'hBEEF_0008;
            @(negedge clk);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++;
                $display("FAIL dly_req c%0d got %b %h exp 1 8", c, imem_req, imem_addr); end
            checks++; if (pc_stall !== (c != 3)) begin errors++;
                $display("FAIL dly_stall c%0d got %b exp %b", c, pc_stall, c != 3); end
            if (c == 3) begin
                checks++; if (pc_next !== 32'hC) begin errors++;
                    $display("FAIL dly_next got %h exp c", pc_next); end
            end
            step();
        end
        imem_ack = 1'b0;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8 ||
                      instr_out !== 32'hBEEF_0008 || imem_addr !== 32'hC) begin errors++;
            $display("FAIL dly_instr got %b %h %h addr %h exp 1 8 beef0008 c",
                     instr_valid, instr_pc, instr_out, imem_addr); end
        step();
    endtask

    task automatic test_hazard_hold();
        boot_and_fetch(4);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678; load_use_hazard = 1'b1;
        @(negedge clk);
        checks++; if (pc_stall !== 1'b1 || flush !== 1'b0) begin errors++;
            $display("FAIL hz_ack got stall %b flush %b exp 1 0", pc_stall, flush); end
        step();
        imem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            load_use_hazard = (c < 2); imem_rdata = $urandom;
            @(negedge clk);
            checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++;
                $display("FAIL hz_hold c%0d got req %b valid %b exp 0 0",
                         c, imem_req, instr_valid); end
            checks++; if (pc_stall !== (c < 2)) begin errors++;
                $display("FAIL hz_stall c%0d got %b exp %b", c, pc_stall, c < 2); end
            if (c == 2) begin
                checks++; if (pc_next !== 32'h14) begin errors++;
                    $display("FAIL hz_next got %h exp 14", pc_next); end
            end
            step();
        end
        load_use_hazard = 1'b0;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h1234_5678 ||
                      instr_pc !== 32'h10 || imem_addr !== 32'h14 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL hz_release got %b %h %h addr %h req %b exp 1 12345678 10 14 1",
                     instr_valid, instr_out, instr_pc, imem_addr, imem_req); end
        step();
    endtask

    task automatic test_redirect_discard();
        boot_and_fetch(2);
        redirect_valid = 1'b1; redirect_target = 32'h0000_0203;
        @(negedge clk);
        checks++; if (flush !== 1'b1 || pc_stall !== 1'b1 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL rd_event got flush %b stall %b req %b exp 1 1 1",
                     flush, pc_stall, imem_req); end
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (flush !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8 ||
                      pc_stall !== 1'b1) begin errors++;
            $display("FAIL rd_discard got %b %b %h %b exp 0 1 8 1",
                     flush, imem_req, imem_addr, pc_stall); end
        step();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_DEAD;
        @(negedge clk);
        checks++; if (pc_stall !== 1'b0 || pc_next !== 32'h200 || flush !== 1'b0) begin
            errors++;
            $display("FAIL rd_ack got %b %h %b exp 0 200 0", pc_stall, pc_next, flush); end
        step();
        imem_rdata = 32'h0000_0200;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h200 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL rd_target got valid %b addr %h req %b exp 0 200 1",
                     instr_valid, imem_addr, imem_req); end
        step();
        imem_ack = 1'b0;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h0000_0200 ||
                      instr_pc !== 32'h200) begin errors++;
            $display("FAIL rd_fetch got %b %h %h exp 1 200 200",
                     instr_valid, instr_out, instr_pc); end
        step();
    endtask

    task automatic test_trap_priority();
        boot_and_fetch(1);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; trap = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'h40;
        @(negedge clk);
        checks++; if (flush !== 1'b1 || pc_stall !== 1'b0 || pc_next !== 32'h100) begin
            errors++;
            $display("FAIL trap_ev got %b %b %h exp 1 0 100", flush, pc_stall, pc_next); end
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0 || imem_addr !== 32'h100) begin errors++;
            $display("FAIL trap_after got valid %b addr %h exp 0 100",
                     instr_valid, imem_addr); end
        step();
    endtask

    task automatic test_reset_in_discard();
        boot_and_fetch(1);
        redirect_valid = 1'b1; redirect_target = 32'h300;
        step();
        redirect_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || flush !== 1'b0 ||
                      pc_stall !== 1'b1 || pc_next !== 32'h0) begin errors++;
            $display("FAIL rsd_async got %b %b %b %b %h exp 0 0 0 1 0",
                     imem_req, instr_valid, flush, pc_stall, pc_next); end
        step();
        step();
        reset = 1'b1;
        step();
        imem_ack = 1'b1; imem_rdata = $urandom;
        @(negedge clk);
        checks++; if (imem_addr !== 32'h0 || pc_next !== 32'h4 || pc_stall !== 1'b0) begin
            errors++;
            $display("FAIL rsd_restart got %h %h %b exp 0 4 0", imem_addr, pc_next, pc_stall);
        end
        step();
        imem_ack = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (flush !== 1'b1 || pc_next !== 32'hFFFF_FFFC || pc_stall !== 1'b0) begin
            errors++;
            $display("FAIL wrap_idle got %b %h %b exp 1 fffffffc 0", flush, pc_next, pc_stall);
        end
        step();
        redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        checks++; if (pc_next !== 32'h0 || pc_stall !== 1'b0) begin errors++;
            $display("FAIL wrap_next got %h %b exp 0 0", pc_next, pc_stall); end
        step();
        imem_ack = 1'b0;
        @(negedge clk);
        checks++; if (instr_pc !== 32'hFFFF_FFFC || instr_valid !== 1'b1 ||
                      imem_addr !== 32'h0) begin errors++;
            $display("FAIL wrap_instr got %h %b %h exp fffffffc 1 0",
                     instr_pc, instr_valid, imem_addr); end
        step();
    endtask

    // Model: a fetch is either booting, waiting on memory (possibly with a kill target
    // queued), or holding a returned word for a stalled downstream.
    task automatic test_random();
        logic        boot, hold_v, kill_v, exp_v, acc, ev, e_req, e_stall;
        logic [31:0] hold_w, hold_pc, kill_t, m_pc, exp_w, exp_pc, tgt, e_next, acc_w;
        do_reset();
        boot = 1'b1; hold_v = 1'b0; kill_v = 1'b0; exp_v = 1'b0;
        hold_w = '0; hold_pc = '0; kill_t = '0; m_pc = '0; exp_w = '0; exp_pc = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            e_req           = !boot && !hold_v;
            load_use_hazard = ($urandom_range(3) == 0);
            redirect_valid  = ($urandom_range(9) == 0);
            trap            = ($urandom_range(19) == 0);
            redirect_target = $urandom;
            imem_rdata      = $urandom;
            imem_ack        = e_req && ($urandom_range(2) != 0);
            @(negedge clk);

            checks++; if (instr_valid !== exp_v) begin errors++;
                $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, instr_valid, exp_v); end
            if (exp_v) begin
                checks++; if (instr_out !== exp_w || instr_pc !== exp_pc) begin errors++;
                    $display("FAIL rnd_instr cyc %0d got %h @%h exp %h @%h",
                             cyc, instr_out, instr_pc, exp_w, exp_pc); end
            end
            if (!boot) begin
                checks++; if (imem_addr !== m_pc) begin errors++;
                    $display("FAIL rnd_addr cyc %0d got %h exp %h", cyc, imem_addr, m_pc); end
            end

            ev = trap || redirect_valid;
            tgt = trap ? 32'h100 : {redirect_target[31:2], 2'b00};
            e_stall = 1'b1; e_next = '0; acc = 1'b0; acc_w = '0;
            if (boot) begin
                e_stall = 1'b0; e_next = ev ? tgt : 32'h0; boot = 1'b0;
            end else if (hold_v) begin
                if (ev) begin
                    e_stall = 1'b0; e_next = tgt; hold_v = 1'b0;
                end else if (!load_use_hazard) begin
                    acc = 1'b1; acc_w = hold_w; e_stall = 1'b0; e_next = m_pc + 32'd4;
                    hold_v = 1'b0;
                end
            end else if (ev) begin
                if (imem_ack) begin
                    e_stall = 1'b0; e_next = tgt; kill_v = 1'b0;
                end else begin
                    kill_v = 1'b1; kill_t = tgt;
                end
            end else if (imem_ack) begin
                if (kill_v) begin
                    e_stall = 1'b0; e_next = kill_t; kill_v = 1'b0;
                end else if (!load_use_hazard) begin
                    acc = 1'b1; acc_w = imem_rdata; e_stall = 1'b0; e_next = m_pc + 32'd4;
                end else begin
                    hold_v = 1'b1; hold_w = imem_rdata; hold_pc = m_pc;
                end
            end

            checks++; if (imem_req !== e_req) begin errors++;
                $display("FAIL rnd_req cyc %0d got %b exp %b", cyc, imem_req, e_req); end
            checks++; if (flush !== ev) begin errors++;
                $display("FAIL rnd_flush cyc %0d got %b exp %b", cyc, flush, ev); end
            checks++; if (pc_stall !== e_stall) begin errors++;
                $display("FAIL rnd_stall cyc %0d got %b exp %b", cyc, pc_stall, e_stall); end
            if (!e_stall) begin
                checks++; if (pc_next !== e_next) begin errors++;
                    $display("FAIL rnd_next cyc %0d got %h exp %h", cyc, pc_next, e_next); end
            end

            if (acc) begin
                exp_w = acc_w; exp_pc = hold_v ? hold_pc : m_pc;
            end
            exp_v = acc;
            if (!e_stall) m_pc = e_next;
            step();
        end
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_sequential();
        test_delayed_ack();
        test_hazard_hold();
        test_redirect_discard();
        test_trap_priority();
        test_reset_in_discard();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
